// File: rtl/multiplier_pipe.sv
// Pipelined W x W multiplier (signed/unsigned per transaction) with valid/ready flow control.
// Define MULTIPLIER_PIPE_ACC_EN to add the in_acc port and accumulate into the output register.
module multiplier_pipe #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
`ifdef MULTIPLIER_PIPE_ACC_EN
    input  logic             in_acc,
`endif
    input  logic [W-1:0]     in0,
    input  logic [W-1:0]     in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out
);

    localparam int LG = $clog2(W);
    localparam int L  = 2 + LG;
    localparam int P  = 2 * W;

    logic           advance;
    logic           acc_in;
    logic           vld [L];
    logic           sgn [L];
    logic           acc [L];
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [P-1:0]   a_ext;
    logic [P-1:0]   pp_c [W];
    // tree[0] is the partial-product register; tree[k] holds W>>k sums, tree[LG][0] is out
    logic [P-1:0]   tree [LG+1][W];

`ifdef MULTIPLIER_PIPE_ACC_EN
    assign acc_in = in_acc;
`else
    assign acc_in = 1'b0;
`endif

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld[L-1];
    assign out       = tree[LG][0];

    // Signed mode: the MSB of in1 carries weight -2^(W-1), so its row is subtracted.
    always_comb begin
        a_ext = sgn[0] ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
        for (int i = 0; i < W; i++) begin
            pp_c[i] = b_q[i] ? (a_ext << i) : '0;
        end
        if (sgn[0] && b_q[W-1]) begin
            pp_c[W-1] = -(a_ext << (W-1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;
            b_q <= '0;
            for (int s = 0; s < L; s++) begin
                vld[s] <= 1'b0;
                sgn[s] <= 1'b0;
                acc[s] <= 1'b0;
            end
            for (int k = 0; k <= LG; k++) begin
                for (int j = 0; j < W; j++) begin
                    tree[k][j] <= '0;
                end
            end
        end else if (advance) begin
            vld[0] <= in_valid;
            sgn[0] <= in_signed;
            acc[0] <= acc_in;
            a_q    <= in0;
            b_q    <= in1;

            vld[1] <= vld[0];
            sgn[1] <= sgn[0];
            acc[1] <= acc[0];
            for (int i = 0; i < W; i++) begin
                tree[0][i] <= pp_c[i];
            end

            for (int k = 1; k <= LG; k++) begin
                vld[k+1] <= vld[k];
                sgn[k+1] <= sgn[k];
                acc[k+1] <= acc[k];
                if (k < LG) begin
                    for (int j = 0; j < (W >> k); j++) begin
                        tree[k][j] <= tree[k-1][2*j] + tree[k-1][2*j+1];
                    end
                end else if (vld[k]) begin
                    // Final level is the output register; it only moves on a real result.
                    tree[k][0] <= (acc[k] ? tree[k][0] : '0) + tree[k-1][0] + tree[k-1][1];
                end
            end
        end
    end

endmodule

// File: tb/tb_multiplier_pipe.sv
// Scoreboard bench for multiplier_pipe: directed W=8 vectors plus W=16 and W=4 random sweeps.
module tb_multiplier_pipe;

    typedef struct {
        logic [31:0] val;
        int          cyc;
        int          st;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    logic        i8_valid, i8_ready, i8_signed, o8_valid, or8;
    logic [7:0]  i8_a, i8_b;
    logic [15:0] o8_out;
`ifdef MULTIPLIER_PIPE_ACC_EN
    logic        acc8;
`endif
    logic        i16_valid, i16_ready, i16_signed, o16_valid, or16;
    logic [15:0] i16_a, i16_b;
    logic [31:0] o16_out;
    logic        i4_valid, i4_ready, i4_signed, o4_valid, or4;
    logic [3:0]  i4_a, i4_b;
    logic [7:0]  o4_out;

    exp_t q8[$];
    exp_t q16[$];
    exp_t q4[$];
    exp_t e8, e16, e4;
    int   stall8 = 0, stall16 = 0, stall4 = 0;
    logic prev_stall8 = 1'b0;
    logic [15:0] prev_out8;
    logic sweep_on = 1'b0;

    multiplier_pipe #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(i8_valid), .in_ready(i8_ready), .in_signed(i8_signed),
`ifdef MULTIPLIER_PIPE_ACC_EN
        .in_acc(acc8),
`endif
        .in0(i8_a), .in1(i8_b), .out_valid(o8_valid), .out_ready(or8), .out(o8_out)
    );

    multiplier_pipe #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(i16_valid), .in_ready(i16_ready), .in_signed(i16_signed),
`ifdef MULTIPLIER_PIPE_ACC_EN
        .in_acc(1'b0),
`endif
        .in0(i16_a), .in1(i16_b), .out_valid(o16_valid), .out_ready(or16), .out(o16_out)
    );

    multiplier_pipe #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(i4_valid), .in_ready(i4_ready), .in_signed(i4_signed),
`ifdef MULTIPLIER_PIPE_ACC_EN
        .in_acc(1'b0),
`endif
        .in0(i4_a), .in1(i4_b), .out_valid(o4_valid), .out_ready(or4), .out(o4_out)
    );

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a,
                                             input logic [31:0] b, input logic s);
        longint sa, sb, p;
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // W=8 monitor: value, latency (5 + stall cycles), hold and in_ready during stalls.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall8 = 1'b0;
        end else begin
            if (prev_stall8) begin
                check("hold_valid8", {63'b0, o8_valid}, 64'd1);
                check("hold_out8", {48'b0, o8_out}, {48'b0, prev_out8});
            end
            if (o8_valid && or8) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected8: got %0h expected none", o8_out);
                end else begin
                    e8 = q8.pop_front();
                    check("prod8", {48'b0, o8_out}, {32'b0, e8.val});
                    check("lat8", 64'(cyc - e8.cyc), 64'(5 + stall8 - e8.st));
                end
            end
            if (o8_valid && !or8) begin
                check("stall_ready8", {63'b0, i8_ready}, 64'd0);
                stall8++;
            end
            prev_stall8 = o8_valid && !or8;
            prev_out8   = o8_out;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (o16_valid && or16) begin
                if (q16.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected16: got %0h expected none", o16_out);
                end else begin
                    e16 = q16.pop_front();
                    check("prod16", {32'b0, o16_out}, {32'b0, e16.val});
                    check("lat16", 64'(cyc - e16.cyc), 64'(6 + stall16 - e16.st));
                end
            end
            if (o16_valid && !or16) stall16++;
            if (o4_valid && or4) begin
                if (q4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected4: got %0h expected none", o4_out);
                end else begin
                    e4 = q4.pop_front();
                    check("prod4", {56'b0, o4_out}, {32'b0, e4.val});
                    check("lat4", 64'(cyc - e4.cyc), 64'(4 + stall4 - e4.st));
                end
            end
            if (o4_valid && !or4) stall4++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (sweep_on) begin
            or16 = ($urandom_range(0, 2) != 0);
            or4  = ($urandom_range(0, 2) != 0);
        end else begin
            or16 = 1'b1;
            or4  = 1'b1;
        end
    end

    task automatic send8(input logic s, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] e);
        int n = 0;
        i8_valid = 1'b1; i8_signed = s; i8_a = a; i8_b = b;
        @(negedge clk);
        while (!i8_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!i8_ready) begin
            checks++;
            errors++;
            $display("FAIL accept8: got in_ready 0 expected 1 within 100 cycles");
        end else begin
            q8.push_back('{val: {16'b0, e}, cyc: cyc, st: stall8});
        end
        @(posedge clk);
        #1;
        i8_valid = 1'b0;
    endtask

    task automatic sweep16(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int n = 0;
            i16_valid = 1'b1;
            i16_a = 16'($urandom);
            i16_b = 16'($urandom);
            i16_signed = 1'($urandom_range(0, 1));
            @(negedge clk);
            while (!i16_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!i16_ready) begin
                checks++;
                errors++;
                $display("FAIL accept16: got in_ready 0 expected 1 within 100 cycles");
            end else begin
                q16.push_back('{val: 32'(ref_prod(16, {16'b0, i16_a}, {16'b0, i16_b}, i16_signed)),
                                cyc: cyc, st: stall16});
            end
            @(posedge clk);
            #1;
            i16_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic sweep4(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int n = 0;
            i4_valid = 1'b1;
            i4_a = 4'($urandom);
            i4_b = 4'($urandom);
            i4_signed = 1'($urandom_range(0, 1));
            @(negedge clk);
            while (!i4_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!i4_ready) begin
                checks++;
                errors++;
                $display("FAIL accept4: got in_ready 0 expected 1 within 100 cycles");
            end else begin
                q4.push_back('{val: 32'(ref_prod(4, {28'b0, i4_a}, {28'b0, i4_b}, i4_signed)),
                               cyc: cyc, st: stall4});
            end
            @(posedge clk);
            #1;
            i4_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q16.size() != 0 || q4.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_timeout", 64'(q8.size() + q16.size() + q4.size()), 64'd0);
    endtask

    logic [15:0] stall_exp [8] = '{16'd200, 16'd231, 16'd264, 16'd299,
                                   16'd336, 16'd375, 16'd416, 16'd459};

    initial begin
        rst = 1'b0;
        i8_valid = 0; i8_signed = 0; i8_a = 0; i8_b = 0; or8 = 1'b1;
        i16_valid = 0; i16_signed = 0; i16_a = 0; i16_b = 0;
        i4_valid = 0; i4_signed = 0; i4_a = 0; i4_b = 0;
`ifdef MULTIPLIER_PIPE_ACC_EN
        acc8 = 1'b0;
`endif
        #2;
        check("rst_out_valid", {63'b0, o8_valid}, 64'd0);
        check("rst_out", {48'b0, o8_out}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rdy_after_rst8", {63'b0, i8_ready}, 64'd1);
        check("rdy_after_rst16", {63'b0, i16_ready}, 64'd1);
        @(posedge clk);
        #1;

        send8(1'b1, 8'h80, 8'h80, 16'h4000);
        drain();
        send8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
        send8(1'b1, 8'hFF, 8'hFF, 16'h0001);
        send8(1'b0, 8'd200, 8'd3, 16'h0258);
        send8(1'b1, 8'h7F, 8'h80, 16'hC080);
        send8(1'b1, 8'h80, 8'h7F, 16'hC080);
        send8(1'b1, 8'h05, 8'hFD, 16'hFFF1);
        send8(1'b0, 8'h80, 8'h02, 16'h0100);
        send8(1'b0, 8'h00, 8'hAB, 16'h0000);
        send8(1'b1, 8'h80, 8'h01, 16'hFF80);
        send8(1'b0, 8'hFF, 8'h01, 16'h00FF);
        drain();

        fork
            begin
                for (int i = 0; i < 8; i++) send8(1'b0, 8'(10 + i), 8'(20 + i), stall_exp[i]);
            end
            begin
                repeat (6) @(posedge clk);
                #1 or8 = 1'b0;
                repeat (3) @(posedge clk);
                #1 or8 = 1'b1;
            end
        join
        drain();

`ifdef MULTIPLIER_PIPE_ACC_EN
        acc8 = 1'b0; send8(1'b1, 8'd3, 8'd4, 16'd12);
        acc8 = 1'b1; send8(1'b1, 8'd2, 8'd5, 16'd22);
        acc8 = 1'b1; send8(1'b1, 8'hFF, 8'd1, 16'd21);
        acc8 = 1'b0;
        drain();
`endif

        send8(1'b0, 8'd9, 8'd9, 16'd81);
        send8(1'b0, 8'd7, 8'd7, 16'd49);
        send8(1'b1, 8'hFE, 8'd3, 16'hFFFA);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_out_valid", {63'b0, o8_valid}, 64'd0);
        check("midrst_out", {48'b0, o8_out}, 64'd0);
        q8.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rdy_after_midrst", {63'b0, i8_ready}, 64'd1);
        repeat (12) @(posedge clk);
        #1;
        check("no_out_after_rst", {63'b0, o8_valid}, 64'd0);

        sweep_on = 1'b1;
        fork
            sweep16(150);
            sweep4(150);
        join
        sweep_on = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500us");
        $fatal(1);
    end

endmodule

// File: doc/multiplier_pipe.md
MULTIPLIER_PIPE -- requirements
Module: multiplier_pipe

Interface
REQ-001 Parameter W, default 8: operand width; legal values 4, 8, 16, 32.
REQ-002 Derived L = 2 + log2(W): pipeline depth in stages (L=5 at W=8).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand transaction present.
REQ-006 in_ready  output  1  block accepts the transaction this cycle.
REQ-007 in_signed  input  1  1 = two's-complement operands, 0 = unsigned operands.
REQ-008 in0, in1  input  W each  operands.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out  output  2W  product (or accumulated sum, see REQ-030).

Function
REQ-012 Transfer on a port occurs only when valid and ready are both 1 in the same cycle.
REQ-013 Pipeline stages: input register, partial-product register, then log2(W) pairwise adder-tree register levels; every stage carries a valid bit and the signed flag.
REQ-014 Global advance = !out_valid || out_ready; every stage register loads only when advance = 1.
REQ-015 in_ready = advance (combinational); no combinational path from in_valid to in_ready.
REQ-016 A stage whose predecessor is invalid loads valid=0 (bubble); data registers of bubble stages need not change.
REQ-017 Latency: a transaction accepted in cycle t produces out_valid=1 in cycle t+L when advance stays 1 throughout.
REQ-018 Throughput: one transaction per cycle with out_ready held at 1.
REQ-019 Stall: while out_valid=1 and out_ready=0, out and out_valid hold, and no stage changes.
REQ-020 Simultaneous out handshake and in handshake in the same cycle both complete; no transaction lost or duplicated.
REQ-021 The out register loads only when advance=1 and the final adder stage is valid; otherwise out holds its last value.
REQ-022 Signed mode: out = exact two's-complement product in 2W bits; no overflow is possible.
REQ-023 Unsigned mode: out = exact unsigned product in 2W bits.
REQ-024 in_signed is captured per transaction; mixed-mode back-to-back transactions each use their own mode.
REQ-025 Results emerge in acceptance order.

Reset
REQ-026 rst=0 immediately clears all stage valid bits, out_valid, and out to 0, independent of clk.
REQ-027 In-flight transactions are discarded on reset; no output is produced for them after release.
REQ-028 After reset release, in_ready=1 on the first cycle.

Configuration
REQ-029 Macro MULTIPLIER_PIPE_ACC_EN, when defined, adds port in_acc (input, 1 bit), carried per transaction through all stages.
REQ-030 With MULTIPLIER_PIPE_ACC_EN and in_acc=1, the out register loads out + product, modulo 2^(2W); with in_acc=0 it loads the product.
REQ-031 Accumulation always adds to the previous result loaded into out, regardless of intervening bubbles or stalls.
REQ-032 Reset clears the accumulation base to 0.
REQ-033 Without MULTIPLIER_PIPE_ACC_EN, port in_acc is absent and out is always the plain product.

Verification
REQ-034 W=8, signed, in0=-128, in1=-128, out_ready=1 -> out=16'h4000 with out_valid exactly 5 cycles after acceptance.
REQ-035 W=8, unsigned, in0=255, in1=255 followed next cycle by signed in0=255 (-1), in1=255 (-1) -> out=16'hFE01, then 16'h0001 on consecutive cycles.
REQ-036 W=8, 8 back-to-back transactions with out_ready=0 from cycle 6 for 3 cycles -> out held steady and in_ready=0 during the stall; all 8 results delivered in order; none dropped or duplicated.
REQ-037 W=8, rst asserted low mid-stream with 3 transactions in flight -> out_valid=0 and out=0 immediately; no results appear after release.
REQ-038 ACC_EN defined, W=8, signed: (3,4,acc=0), (2,5,acc=1), (-1,1,acc=1) -> outputs 12, 22, 21.
REQ-039 W=16 and W=4 random signed/unsigned sweep with random out_ready -> every output equals the reference product; observed latency = L when not stalled.
